// File: rtl/stroke_word_plotter_pkg.sv
// Shared stroke definitions: direction codes, FSM states,
// glyph origins and the ROM entry layout.
package stroke_defs;

  localparam logic [1:0] DIR_H  = 2'd0;
  localparam logic [1:0] DIR_V  = 2'd1;
  localparam logic [1:0] DIR_DN = 2'd2;
  localparam logic [1:0] DIR_UP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLOT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [7:0] GL_X = 8'd10;
  localparam logic [7:0] GI_X = 8'd14;
  localparam logic [7:0] GV_X = 8'd20;
  localparam logic [7:0] GE_X = 8'd30;
  localparam logic [6:0] G_Y  = 7'd10;

  typedef struct packed {
    logic [7:0] x0;
    logic [6:0] y0;
    logic [1:0] dir;
  } stroke_t;

endpackage

// File: rtl/stroke_rom.sv
// Word table ROM (combinational): idx -> {x0, y0, dir}.
// Ports: idx_i stroke index, stroke_o table entry.
module stroke_rom
  import stroke_defs::*;
#(
  parameter int IW = 4
) (
  input  logic [IW-1:0] idx_i,
  output stroke_t       stroke_o
);

  always_comb begin
    stroke_o = '0;
    case (int'(idx_i))
      0:  stroke_o = '{GL_X,        G_Y,        DIR_V};
      1:  stroke_o = '{GL_X,        G_Y + 7'd4, DIR_H};
      2:  stroke_o = '{GI_X,        G_Y,        DIR_H};
      3:  stroke_o = '{GI_X + 8'd2, G_Y,        DIR_V};
      4:  stroke_o = '{GI_X,        G_Y + 7'd4, DIR_H};
      5:  stroke_o = '{GV_X,        G_Y,        DIR_DN};
      6:  stroke_o = '{GV_X + 8'd4, G_Y + 7'd4, DIR_UP};
      7:  stroke_o = '{GE_X,        G_Y,        DIR_V};
      8:  stroke_o = '{GE_X,        G_Y,        DIR_H};
      9:  stroke_o = '{GE_X,        G_Y + 7'd2, DIR_H};
      10: stroke_o = '{GE_X,        G_Y + 7'd4, DIR_H};
      default: stroke_o = '0;
    endcase
  end

endmodule

// File: rtl/stroke_word_plotter.sv
// Stroke-list plotter: one pixel per clock for vga_adapter.
// Ports: clk/reset_n, start/erase/org/colour in; x/y/colour_out/plot/busy/done out.
module stroke_word_plotter
  import stroke_defs::*;
#(
  parameter int NUM_STROKES = 11,
  parameter int STROKE_LEN  = 5,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOUR_W    = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                erase,
  input  logic [X_W-1:0]      org_x,
  input  logic [Y_W-1:0]      org_y,
  input  logic [COLOUR_W-1:0] colour,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int IW = (NUM_STROKES > 1) ? $clog2(NUM_STROKES) : 1;
  localparam int SW = $clog2(STROKE_LEN);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STROKES - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(STROKE_LEN - 1);

  state_e                state_q;
  logic [IW-1:0]         idx_q;
  logic [SW-1:0]         step_q;
  logic [X_W-1:0]        ox_q;
  logic [Y_W-1:0]        oy_q;
  logic [COLOUR_W-1:0]   col_q;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [COLOUR_W-1:0]   cout_q;
  logic                  plot_q, busy_q, done_q;
  stroke_t               stk;
  logic [X_W-1:0]        sx;
  logic [Y_W-1:0]        sy;

  stroke_rom #(.IW(IW)) u_rom (
    .idx_i    (idx_q),
    .stroke_o (stk)
  );

  assign sx = X_W'(step_q);
  assign sy = Y_W'(step_q);

  always_comb begin
    x_d = ox_q + X_W'(stk.x0);
    y_d = oy_q + Y_W'(stk.y0);
    case (stk.dir)
      DIR_H: x_d = x_d + sx;
      DIR_V: y_d = y_d + sy;
      DIR_DN: begin
        x_d = x_d + sx;
        y_d = y_d + sy;
      end
      default: begin
        x_d = x_d + sx;
        y_d = y_d - sy;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      step_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      col_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cout_q  <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      plot_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_PLOT;
            ox_q    <= org_x;
            oy_q    <= org_y;
            col_q   <= erase ? '0 : colour;
            idx_q   <= '0;
            step_q  <= '0;
          end
        end
        S_PLOT: begin
          x_q    <= x_d;
          y_q    <= y_d;
          cout_q <= col_q;
          plot_q <= 1'b1;
          busy_q <= 1'b1;
          if (step_q == LAST_STEP) begin
            step_q <= '0;
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              state_q <= S_DONE;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end else begin
            step_q <= step_q + SW'(1);
          end
        end
        S_DONE: begin
          // done is registered, so it lands one cycle after the last pixel
          done_q <= 1'b1;
          if (start) begin
            state_q <= S_PLOT;
            ox_q    <= org_x;
            oy_q    <= org_y;
            col_q   <= erase ? '0 : colour;
            idx_q   <= '0;
            step_q  <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign colour_out = cout_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
